// File: rtl/mcu_reg_writer_pkg.sv
// ============================================================================
// Module   : fpga2mcu_pkg
// Brief    : Shared types and constants for the MCU register writer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpga2mcu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        WAIT_WE = 2'd2,
        WRITE   = 2'd3
    } state_t;

    localparam logic [15:0] c_off_freq_lo = 16'h0001;
    localparam logic [15:0] c_off_freq_hi = 16'h0002;
    localparam logic [15:0] c_off_phase   = 16'h0003;
    localparam logic [15:0] c_off_ctrl    = 16'h0004;

    localparam int c_ctrl_clr_err_bit = 14;
    localparam int c_ctrl_commit_bit  = 15;

    localparam logic [2:0] c_base_hi_default = 3'b101;

endpackage

`default_nettype wire

// File: rtl/mcu_reg_writer_if.sv
// ============================================================================
// Module   : mcu_reg_writer_if
// Brief    : MCU multiplexed bus plus committed DDS control outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mcu_reg_writer_if;
    logic        NADV;
    logic        NWE;
    logic [15:0] AD_IN;
    logic        A16;
    logic        A17;
    logic        A18;
    logic [31:0] FREQ_WORD;
    logic [15:0] PHASE_WORD;
    logic [1:0]  WAVE_SEL;
    logic        UPDATE;
    logic        ERR_ADDR;

    modport master (
        output NADV, NWE, AD_IN, A16, A17, A18,
        input  FREQ_WORD, PHASE_WORD, WAVE_SEL, UPDATE, ERR_ADDR
    );

    modport slave (
        input  NADV, NWE, AD_IN, A16, A17, A18,
        output FREQ_WORD, PHASE_WORD, WAVE_SEL, UPDATE, ERR_ADDR
    );
endinterface

`default_nettype wire

// File: rtl/mcu_reg_writer_strobe_sync.sv
// ============================================================================
// Module   : strobe_sync
// Brief    : Strobe synchronizer with width-qualified rise/fall detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_rise,
    output logic      o_fall
);

    localparam int CW = $clog2(SYNC_STAGES + 1);
    localparam int FW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] c_min  = CW'(SYNC_STAGES);
    localparam logic [FW-1:0] c_fill = FW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CW-1:0]          r_cnt;
    logic [FW-1:0]          r_fill;
    logic                   w_sync;
    logic                   w_filled;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_filled = (r_fill == c_fill);

    // Edges are reported only once the chain holds real samples and the
    // preceding level was stable long enough, so glitches and the reset
    // flush never look like strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_cnt  <= '0;
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= w_sync;
            if (!w_filled) begin
                r_fill <= r_fill + FW'(1);
            end
            if (!w_filled || (w_sync != r_prev)) begin
                r_cnt <= '0;
            end else if (r_cnt != c_min) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_rise = w_filled &  w_sync & ~r_prev & (r_cnt == c_min);
    assign o_fall = w_filled & ~w_sync &  r_prev & (r_cnt == c_min);

endmodule

`default_nettype wire

// File: rtl/mcu_reg_writer.sv
// ============================================================================
// Module   : mcu_reg_writer
// Brief    : Decodes MCU bus writes into shadowed, commit-on-CTRL DDS words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_reg_writer
    import fpga2mcu_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] BASE_HI     = c_base_hi_default
) (
    input  wire logic        CLK,
    input  wire logic        RST,
    mcu_reg_writer_if.slave  bus
);

    logic w_nadv_rise, w_nadv_fall, w_nwe_rise, w_nwe_fall;

    strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_nadv_sync (
        .clk     (CLK),
        .rst     (RST),
        .i_async (bus.NADV),
        .o_rise  (w_nadv_rise),
        .o_fall  (w_nadv_fall)
    );

    strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_nwe_sync (
        .clk     (CLK),
        .rst     (RST),
        .i_async (bus.NWE),
        .o_rise  (w_nwe_rise),
        .o_fall  (w_nwe_fall)
    );

    // Bus delayed by the synchronizer depth so sampling matches the strobes.
    logic [SYNC_STAGES-1:0][18:0] r_bus_pipe;
    logic [18:0]                  w_bus_aligned;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_bus_pipe <= '0;
        end else begin
            r_bus_pipe <= {r_bus_pipe[SYNC_STAGES-2:0],
                           {bus.A18, bus.A17, bus.A16, bus.AD_IN}};
        end
    end

    assign w_bus_aligned = r_bus_pipe[SYNC_STAGES-1];

    state_t      r_state, w_state_next;
    logic        w_addr_load, w_data_load;
    logic [18:0] r_addr;
    logic [15:0] r_wdata;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_addr_load  = 1'b0;
        w_data_load  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_nadv_rise) begin
                    w_state_next = ADDR;
                    w_addr_load  = 1'b1;
                end
            end
            ADDR: begin
                if (w_nadv_fall || (r_addr[18:16] != BASE_HI)) begin
                    w_state_next = IDLE;
                end else if (w_nwe_fall) begin
                    w_state_next = WAIT_WE;
                end
            end
            WAIT_WE: begin
                if (w_nadv_fall) begin
                    w_state_next = IDLE;
                end else if (w_nwe_rise) begin
                    w_state_next = WRITE;
                    w_data_load  = 1'b1;
                end
            end
            WRITE:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    logic [31:0] r_freq_sh, r_freq_word;
    logic [15:0] r_phase_sh, r_phase_word;
    logic [1:0]  r_wave_sh, r_wave_sel;
    logic        r_update, r_err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_freq_sh    <= '0;
            r_phase_sh   <= '0;
            r_wave_sh    <= '0;
            r_freq_word  <= '0;
            r_phase_word <= '0;
            r_wave_sel   <= '0;
            r_update     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_update <= 1'b0;
            if (w_addr_load) begin
                r_addr <= w_bus_aligned;
            end
            if (w_data_load) begin
                r_wdata <= w_bus_aligned[15:0];
            end
            if (r_state == WRITE) begin
                case (r_addr[15:0])
                    c_off_freq_lo: r_freq_sh[15:0]  <= r_wdata;
                    c_off_freq_hi: r_freq_sh[31:16] <= r_wdata;
                    c_off_phase:   r_phase_sh       <= r_wdata;
                    c_off_ctrl: begin
                        r_wave_sh <= r_wdata[1:0];
                        if (r_wdata[c_ctrl_clr_err_bit]) begin
                            r_err <= 1'b0;
                        end
                        // Wave select comes straight from this write so a
                        // single CTRL access can both select and commit.
                        if (r_wdata[c_ctrl_commit_bit]) begin
                            r_freq_word  <= r_freq_sh;
                            r_phase_word <= r_phase_sh;
                            r_wave_sel   <= r_wdata[1:0];
                            r_update     <= 1'b1;
                        end
                    end
                    default: r_err <= 1'b1;
                endcase
            end
        end
    end

    assign bus.FREQ_WORD  = r_freq_word;
    assign bus.PHASE_WORD = r_phase_word;
    assign bus.WAVE_SEL   = r_wave_sel;
    assign bus.UPDATE     = r_update;
    assign bus.ERR_ADDR   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mcu_reg_writer.sv
// ============================================================================
// Module   : tb_mcu_reg_writer
// Brief    : Scoreboard bench for mcu_reg_writer with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcu_reg_writer;

    localparam int         SYNC = 2;
    localparam logic [2:0] BASE = 3'b101;
    localparam int         W    = SYNC + 4;

    logic clk;
    logic rst;
    mcu_reg_writer_if bus ();

    mcu_reg_writer #(.SYNC_STAGES(SYNC), .BASE_HI(BASE)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [31:0] m_freq_sh, m_freq;
    logic [15:0] m_phase_sh, m_phase;
    logic [1:0]  m_wave_sh, m_wave;
    logic        m_err;
    logic [49:0] exp_q[$];

    function automatic void model_reset();
        m_freq_sh = '0; m_freq = '0;
        m_phase_sh = '0; m_phase = '0;
        m_wave_sh = '0; m_wave = '0;
        m_err = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_write(input logic [2:0] hi, input logic [15:0] off,
                                        input logic [15:0] d);
        if (hi != BASE) return;
        case (off)
            16'h0001: m_freq_sh[15:0]  = d;
            16'h0002: m_freq_sh[31:16] = d;
            16'h0003: m_phase_sh       = d;
            16'h0004: begin
                m_wave_sh = d[1:0];
                if (d[14]) m_err = 1'b0;
                if (d[15]) begin
                    m_freq  = m_freq_sh;
                    m_phase = m_phase_sh;
                    m_wave  = d[1:0];
                    exp_q.push_back({m_freq, m_phase, m_wave});
                end
            end
            default: m_err = 1'b1;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s actual=%h expected=%h", name, act, exp);
        else n_pass++;
    endtask

    task automatic check_status(input string name);
        n_checks++;
        if ({bus.FREQ_WORD, bus.PHASE_WORD, bus.WAVE_SEL, bus.ERR_ADDR} !==
            {m_freq, m_phase, m_wave, m_err})
            $display("FAIL %s actual=%h/%h/%h/%b expected=%h/%h/%h/%b", name,
                     bus.FREQ_WORD, bus.PHASE_WORD, bus.WAVE_SEL, bus.ERR_ADDR,
                     m_freq, m_phase, m_wave, m_err);
        else n_pass++;
    endtask

    // One MCU bus write; short strobe widths or a mid-write reset drop it.
    task automatic bus_write(input logic [2:0] hi, input logic [15:0] off,
                             input logic [15:0] d, input int nadv_low,
                             input int we_low, input bit rst_mid);
        {bus.A18, bus.A17, bus.A16} = hi;
        bus.AD_IN = off;
        cyc(2);
        bus.NADV = 1'b0;
        cyc(nadv_low);
        bus.NADV = 1'b1;
        cyc(3);
        bus.AD_IN = d;
        cyc(2);
        bus.NWE = 1'b0;
        cyc(we_low);
        if (rst_mid) begin
            rst = 1'b1;
            model_reset();
            cyc(3);
            rst = 1'b0;
            cyc(2);
        end else if (nadv_low >= SYNC + 2 && we_low >= SYNC + 2) begin
            model_write(hi, off, d);
        end
        bus.NWE = 1'b1;
        cyc(3);
        bus.AD_IN = 16'($urandom);
        cyc(W + 2);
    endtask

    // Monitor: every UPDATE cycle must match the next expected commit
    logic [49:0] mon_got, mon_exp;
    always @(negedge clk) begin
        if (!rst && bus.UPDATE === 1'b1) begin
            mon_got = {bus.FREQ_WORD, bus.PHASE_WORD, bus.WAVE_SEL};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL update_unexpected actual=%h expected=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp)
                    $display("FAIL update_commit actual=%h expected=%h", mon_got, mon_exp);
                else n_pass++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  hi;
        logic [15:0] off, d;
        int          sel;

        model_reset();
        rst = 1'b1;
        bus.NADV = 1'b1; bus.NWE = 1'b1; bus.AD_IN = '0;
        {bus.A18, bus.A17, bus.A16} = 3'b000;
        cyc(3);
        rst = 1'b0;
        cyc(8);
        check_status("reset_state");
        check("reset_update", {63'd0, bus.UPDATE}, 64'd0);

        // Two shadow writes then commit with wave select 2
        bus_write(BASE, 16'h0001, 16'h5678, W, W, 1'b0);
        bus_write(BASE, 16'h0002, 16'h1234, W, W, 1'b0);
        check_status("shadow_no_commit");
        bus_write(BASE, 16'h0004, 16'h8002, W, W, 1'b0);
        check_status("commit_freq");
        check("commit_freq_const", {32'd0, bus.FREQ_WORD}, 64'h12345678);
        check("commit_wave_const", {62'd0, bus.WAVE_SEL}, 64'd2);

        bus_write(BASE, 16'h0003, 16'h00FF, W, W, 1'b0);
        check_status("phase_uncommitted");
        check("phase_still_zero", {48'd0, bus.PHASE_WORD}, 64'd0);

        bus_write(BASE, 16'h0009, 16'hBEEF, W, W, 1'b0);
        check_status("unmapped_sets_err");
        check("err_set_const", {63'd0, bus.ERR_ADDR}, 64'd1);
        bus_write(BASE, 16'h0004, 16'h4000, W, W, 1'b0);
        check_status("ctrl_clears_err");

        bus_write(3'b011, 16'h0001, 16'hAAAA, W, W, 1'b0);
        check_status("base_miss");
        bus_write(BASE, 16'h0004, 16'h8000, W, W, 1'b0);
        check_status("recommit_after_miss");

        bus_write(BASE, 16'h0000, 16'h0000, W, W, 1'b0);
        bus_write(BASE, 16'h0004, 16'hC001, W, W, 1'b0);
        check_status("clear_and_commit");

        bus_write(BASE, 16'h0004, 16'h8003, W, 1, 1'b0);
        check_status("short_nwe_no_write");
        bus_write(BASE, 16'h0004, 16'h8003, 1, W, 1'b0);
        check_status("short_nadv_no_write");

        bus_write(BASE, 16'h0004, 16'h8003, W, W, 1'b1);
        check_status("reset_mid_write");
        check("reset_mid_freq", {32'd0, bus.FREQ_WORD}, 64'd0);

        for (int k = 0; k < 48; k++) begin
            hi  = ($urandom_range(0, 99) < 80) ? BASE : 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 7);
            off = (sel <= 5) ? 16'(sel) : (sel == 6) ? 16'($urandom) : 16'h0004;
            d   = 16'($urandom);
            if (off == 16'h0004 && $urandom_range(0, 1) == 1) d[15] = 1'b1;
            bus_write(hi, off, d,
                      ($urandom_range(0, 9) == 0) ? 1 : W,
                      ($urandom_range(0, 9) == 0) ? 1 : W, 1'b0);
            check_status("random_txn");
        end

        cyc(5);
        check("commits_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
